anton_neopixel_bit_encoder: RTL and testbench

ANTON_NEOPIXEL_BIT_ENCODER -- requirements
Module: anton_neopixel_bit_encoder

---
 rtl/anton_neopixel_bit_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_anton_neopixel_bit_encoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_bit_encoder.sv
// ---------------------------------------------------------------------------
// anton_neopixel_bit_encoder
//
// Purpose
//   Turns pixel buffer bytes into the NeoPixel one-wire waveform. Each bit is
//   eight sub-bit ticks long. The line is high for T0H_TICKS ticks for a 0
//   and for T1H_TICKS ticks for a 1. The MSB goes out first. The upstream
//   stream logic owns the bit/tick counters; this block only fetches the byte,
//   shifts it out and shapes the line.
//
// Ports
//   clk6_4mhz     in   sole clock, one tick per sub-bit step
//   rst           in   synchronous active-high reset
//   streamOutput  in   upstream is transmitting
//   streamReset   in   upstream is in the reset/latch gap
//   bitPatternIx  in   sub-bit tick 0..7
//   pixelBitIx    in   bit within the byte 0..7 (MSB first)
//   pixelIxComb   in   buffer address of the byte being sent
//   regCtrlInvert in   invert the physical line polarity
//   underrunClr   in   clears the underrun sticky flag
//   ramReq        out  byte read request to the buffer arbiter
//   ramAddr       out  byte address of the read
//   ramAck        in   ramData is valid this cycle
//   ramData       in   read data
//   neoData       out  registered serial line
//   underrun      out  sticky: a byte was not delivered in time
//   bytesSent     out  bytes fully transmitted since reset (wraps)
//
// Fetch FSM
//   state      | meaning
//   FETCH_IDLE | no read outstanding; a read starts on tick 0 of bit 0
//   FETCH_WAIT | read outstanding, waiting for ramAck until end of tick 1
// ---------------------------------------------------------------------------

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 63
`endif

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module anton_neopixel_bit_encoder #(
    parameter int BUFFER_END  = `BUFFER_END_DEFAULT,
    parameter int T0H_TICKS   = 2,
    parameter int T1H_TICKS   = 5,
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input  logic                   clk6_4mhz,
    input  logic                   rst,
    input  logic                   streamOutput,
    input  logic                   streamReset,
    input  logic [2:0]             bitPatternIx,
    input  logic [2:0]             pixelBitIx,
    input  logic [BUFFER_BITS-1:0] pixelIxComb,
    input  logic                   regCtrlInvert,
    input  logic                   underrunClr,
    output logic                   ramReq,
    output logic [BUFFER_BITS-1:0] ramAddr,
    input  logic                   ramAck,
    input  logic [7:0]             ramData,
    output logic                   neoData,
    output logic                   underrun,
    output logic [15:0]            bytesSent
);

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

    // Tick thresholds widened by one bit so the compare never wraps.
    localparam logic [3:0] T0H_W = 4'(T0H_TICKS);
    localparam logic [3:0] T1H_W = 4'(T1H_TICKS);

    fetch_state_t           r_fetch_state;
    fetch_state_t           w_fetch_next;

    logic [BUFFER_BITS-1:0] r_ram_addr;
    logic [7:0]             r_shreg;
    logic                   r_neo;
    logic                   r_underrun;
    logic [15:0]            r_bytes_sent;

    logic                   w_active;
    logic                   w_fetch_start;
    logic                   w_ram_req;
    logic [BUFFER_BITS-1:0] w_ram_addr;
    logic                   w_addr_load;
    logic                   w_shreg_load;
    logic [7:0]             w_shreg_value;
    logic                   w_underrun_set;
    logic                   w_shift;
    logic                   w_byte_done;
    logic                   w_raw;

    assign w_active      = streamOutput && !streamReset;
    assign w_fetch_start = !rst && w_active &&
                           (pixelBitIx == 3'd0) && (bitPatternIx == 3'd0);
    assign w_shift       = streamOutput && (bitPatternIx == 3'd7);
    assign w_byte_done   = streamOutput && (pixelBitIx == 3'd7) &&
                           (bitPatternIx == 3'd7);

    // Ticks 0 and 1 are high for either bit value, so the byte only has to be
    // in the shift register by the end of tick 1.
    assign w_raw = w_active &&
                   (({1'b0, bitPatternIx} < T0H_W) ||
                    (({1'b0, bitPatternIx} < T1H_W) && r_shreg[7]));

    always_ff @(posedge clk6_4mhz) begin
        if (rst) begin
            r_fetch_state <= FETCH_IDLE;
        end else begin
            r_fetch_state <= w_fetch_next;
        end
    end

    // The request is raised combinationally on tick 0 so that an arbiter
    // answering in the same cycle still lands the byte in time.
    always_comb begin
        w_fetch_next   = r_fetch_state;
        w_ram_req      = 1'b0;
        w_ram_addr     = r_ram_addr;
        w_addr_load    = 1'b0;
        w_shreg_load   = 1'b0;
        w_shreg_value  = ramData;
        w_underrun_set = 1'b0;

        case (r_fetch_state)
            FETCH_IDLE: begin
                if (w_fetch_start) begin
                    w_ram_req   = 1'b1;
                    w_ram_addr  = pixelIxComb;
                    w_addr_load = 1'b1;
                    if (ramAck) begin
                        w_shreg_load = 1'b1;
                    end else begin
                        w_fetch_next = FETCH_WAIT;
                    end
                end
            end
            FETCH_WAIT: begin
                w_ram_req = 1'b1;
                if (ramAck) begin
                    w_shreg_load = 1'b1;
                    w_fetch_next = FETCH_IDLE;
                end else if (!streamOutput) begin
                    // Upstream stopped mid-fetch: abandon quietly, keep shreg.
                    w_fetch_next = FETCH_IDLE;
                end else if (bitPatternIx == 3'd1) begin
                    // Out of time: send a dark byte and flag it.
                    w_shreg_load   = 1'b1;
                    w_shreg_value  = 8'h00;
                    w_underrun_set = 1'b1;
                    w_fetch_next   = FETCH_IDLE;
                end
            end
            default: begin
                w_fetch_next = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk6_4mhz) begin
        if (rst) begin
            r_ram_addr   <= '0;
            r_shreg      <= 8'h00;
            r_neo        <= regCtrlInvert;
            r_underrun   <= 1'b0;
            r_bytes_sent <= 16'h0000;
        end else begin
            if (w_addr_load) begin
                r_ram_addr <= pixelIxComb;
            end

            if (w_shreg_load) begin
                r_shreg <= w_shreg_value;
            end else if (w_shift) begin
                r_shreg <= {r_shreg[6:0], 1'b0};
            end

            // Set wins over a simultaneous clear so no underrun is lost.
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (underrunClr) begin
                r_underrun <= 1'b0;
            end

            if (w_byte_done) begin
                r_bytes_sent <= r_bytes_sent + 16'd1;
            end

            r_neo <= w_raw ^ regCtrlInvert;
        end
    end

    assign ramReq    = w_ram_req;
    assign ramAddr   = w_ram_addr;
    assign neoData   = r_neo;
    assign underrun  = r_underrun;
    assign bytesSent = r_bytes_sent;

endmodule

// File: tb/tb_anton_neopixel_bit_encoder.sv
module tb_anton_neopixel_bit_encoder;

    localparam int BUFFER_END = 63;
    localparam int AW         = $clog2(BUFFER_END + 1);
    localparam int T0H        = 2;
    localparam int T1H        = 5;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, so, sr, inv, clr, ack;
    logic [2:0]    bp, pb;
    logic [AW-1:0] pix;
    logic [7:0]    data;
    logic          ram_req;
    logic [AW-1:0] ram_addr;
    logic          neo, und;
    logic [15:0]   bytes_sent;

    anton_neopixel_bit_encoder #(
        .BUFFER_END (BUFFER_END),
        .T0H_TICKS  (T0H),
        .T1H_TICKS  (T1H)
    ) dut (
        .clk6_4mhz     (clk),
        .rst           (rst),
        .streamOutput  (so),
        .streamReset   (sr),
        .bitPatternIx  (bp),
        .pixelBitIx    (pb),
        .pixelIxComb   (pix),
        .regCtrlInvert (inv),
        .underrunClr   (clr),
        .ramReq        (ram_req),
        .ramAddr       (ram_addr),
        .ramAck        (ack),
        .ramData       (data),
        .neoData       (neo),
        .underrun      (und),
        .bytesSent     (bytes_sent)
    );

    // Reference model: the byte the wire should carry, sticky flag, counter.
    logic [7:0] m_byte;
    logic       m_neo;
    logic       m_und;
    int         m_bytes;
    logic       set_und_now;
    logic       samples[$];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  d;
        logic        inv;
        int          delay;   // tick of bit 0 where ack comes; 9 = never
        logic [31:0] hi;      // expected high ticks per bit, MSB bit in top nibble
        logic        und;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One tick: inputs already driven by the caller.
    task automatic cycle(input logic exp_req, input logic [AW-1:0] exp_addr);
        logic bitval;
        #1;
        chk("ramReq", ram_req, exp_req);
        if (exp_req) chk("ramAddr", ram_addr, exp_addr);
        @(posedge clk);
        if (rst) begin
            m_neo   = inv;
            m_und   = 1'b0;
            m_bytes = 0;
            m_byte  = 8'h00;
        end else begin
            bitval = m_byte[3'd7 - pb];
            m_neo  = ((so && !sr && ((int'(bp) < T0H) || ((int'(bp) < T1H) && bitval)))
                      ? 1'b1 : 1'b0) ^ inv;
            if (set_und_now) m_und = 1'b1;
            else if (clr)    m_und = 1'b0;
            if (so && pb == 3'd7 && bp == 3'd7) m_bytes = (m_bytes + 1) % 65536;
        end
        #1;
        chk("neoData", neo, m_neo);
        chk("underrun", und, m_und);
        chk("bytesSent", bytes_sent, m_bytes[15:0]);
        samples.push_back(neo);
        set_und_now = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int delay,
                             input logic [AW-1:0] p, input logic clr_en);
        for (int pbi = 0; pbi < 8; pbi++) begin
            for (int bpi = 0; bpi < 8; bpi++) begin
                rst = 1'b0; so = 1'b1; sr = 1'b0;
                pb  = 3'(pbi); bp = 3'(bpi);
                pix = (pbi == 0 && bpi == 0) ? p : AW'($urandom_range(0, BUFFER_END));
                if (pbi == 0 && bpi == 0) m_byte = (delay <= 1) ? d : 8'h00;
                if (pbi == 0 && bpi == delay) begin
                    ack = 1'b1; data = d;
                end else if (pbi != 0 || bpi >= 2) begin
                    ack = ($urandom_range(0, 7) == 0); data = 8'($urandom);
                end else begin
                    ack = 1'b0; data = 8'($urandom);
                end
                clr = clr_en && ($urandom_range(0, 15) == 0);
                set_und_now = (pbi == 0 && bpi == 1 && delay >= 2);
                cycle(pbi == 0 && (bpi == 0 || (bpi == 1 && delay >= 1)), p);
            end
        end
    endtask

    task automatic idle(input int n, input logic srv, input logic clrv);
        for (int i = 0; i < n; i++) begin
            rst = 1'b0; so = 1'b0; sr = srv; clr = clrv;
            pb = 3'($urandom); bp = 3'($urandom);
            ack = ($urandom_range(0, 3) == 0); data = 8'($urandom);
            pix = AW'($urandom_range(0, BUFFER_END));
            cycle(1'b0, '0);
        end
    endtask

    initial begin
        logic [31:0] hi;
        logic [AW-1:0] p;
        int cnt;
        int dl[6];

        tbl[0] = '{d: 8'hA5, inv: 1'b0, delay: 0, hi: 32'h52522525, und: 1'b0};
        tbl[1] = '{d: 8'hA5, inv: 1'b0, delay: 1, hi: 32'h52522525, und: 1'b0};
        tbl[2] = '{d: 8'h3C, inv: 1'b0, delay: 9, hi: 32'h22222222, und: 1'b1};
        tbl[3] = '{d: 8'hFF, inv: 1'b1, delay: 0, hi: 32'h33333333, und: 1'b0};
        tbl[4] = '{d: 8'h00, inv: 1'b1, delay: 1, hi: 32'h66666666, und: 1'b0};
        tbl[5] = '{d: 8'h81, inv: 1'b0, delay: 2, hi: 32'h22222222, und: 1'b1};
        tbl[6] = '{d: 8'h81, inv: 1'b0, delay: 0, hi: 32'h52222225, und: 1'b0};
        dl = '{0, 1, 0, 1, 2, 9};

        rst = 1'b1; so = 1'b0; sr = 1'b0; inv = 1'b0; clr = 1'b0; ack = 1'b0;
        bp = 3'd0; pb = 3'd0; pix = '0; data = 8'h00;
        m_byte = 8'h00; m_neo = 1'b0; m_und = 1'b0; m_bytes = 0; set_und_now = 1'b0;

        // Reset state
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        chk("reset_neo", neo, 1'b0);
        chk("reset_addr", ram_addr, '0);
        chk("reset_bytes", bytes_sent, 16'h0000);
        chk("reset_und", und, 1'b0);

        // Table-driven single-byte waveforms
        for (int i = 0; i < 7; i++) begin
            inv = tbl[i].inv;
            idle(2, 1'b1, 1'b0);
            samples.delete();
            send_byte(tbl[i].d, tbl[i].delay, AW'($urandom_range(0, BUFFER_END)), 1'b0);
            hi = tbl[i].hi;
            for (int b = 0; b < 8; b++) begin
                cnt = 0;
                for (int k = 0; k < 8; k++) cnt += samples[b * 8 + k] ? 1 : 0;
                chk($sformatf("hi_ticks_v%0d_b%0d", i, b), 32'(cnt), {28'h0, hi[31 - 4 * b -: 4]});
            end
            chk($sformatf("underrun_v%0d", i), und, tbl[i].und);
            idle(1, 1'b1, 1'b1);
            chk($sformatf("underrun_clr_v%0d", i), und, 1'b0);
            chk($sformatf("idle_inv_v%0d", i), neo, tbl[i].inv);
        end

        // Three bytes then a 20-tick latch gap
        inv = 1'b0;
        rst = 1'b1; cycle(1'b0, '0); rst = 1'b0;
        for (int i = 0; i < 3; i++)
            send_byte(8'($urandom), $urandom_range(0, 1), AW'($urandom_range(0, BUFFER_END)), 1'b0);
        idle(20, 1'b1, 1'b0);
        chk("bytes_after_three", bytes_sent, 16'd3);
        chk("latch_idle", neo, 1'b0);

        // Reset during tick 1 of an outstanding fetch; late ack must not land
        p = 6'd37;
        rst = 1'b0; so = 1'b1; sr = 1'b0; pb = 3'd0; bp = 3'd0; pix = p; ack = 1'b0; clr = 1'b0;
        m_byte = 8'h00;
        cycle(1'b1, p);
        rst = 1'b1; bp = 3'd1;
        cycle(1'b1, p);
        chk("rst_mid_addr", ram_addr, '0);
        chk("rst_mid_bytes", bytes_sent, 16'h0000);
        rst = 1'b0;
        for (int k = 2; k < 64; k++) begin
            pb = 3'(k / 8); bp = 3'(k % 8); so = 1'b1; ack = 1'b1; data = 8'hFF;
            pix = AW'($urandom_range(0, BUFFER_END));
            cycle(1'b0, '0);
        end

        // Upstream stops during the fetch window
        p = 6'd12;
        so = 1'b1; pb = 3'd0; bp = 3'd0; pix = p; ack = 1'b0; m_byte = 8'h00;
        cycle(1'b1, p);
        so = 1'b0; bp = 3'd1;
        cycle(1'b1, p);
        for (int k = 2; k < 8; k++) begin
            bp = 3'(k); cycle(1'b0, '0);
        end
        chk("stop_no_underrun", und, 1'b0);
        send_byte(8'hC3, 1, 6'd5, 1'b0);

        // Randomized frames against the model
        for (int f = 0; f < 30; f++) begin
            inv = 1'($urandom);
            for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                send_byte(8'($urandom), dl[$urandom_range(0, 5)],
                          AW'($urandom_range(0, BUFFER_END)), 1'b1);
            idle($urandom_range(2, 10), 1'($urandom), 1'b0);
        end

        // Counter wrap
        inv = 1'b0;
        rst = 1'b1; cycle(1'b0, '0);
        rst = 1'b0; so = 1'b1; sr = 1'b0; pb = 3'd7; bp = 3'd7; ack = 1'b0; clr = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        m_bytes = 65535; m_neo = inv;
        chk("bytes_preload", bytes_sent, 16'hFFFF);
        send_byte(8'h5A, 0, 6'd1, 1'b0);
        chk("bytes_wrap", bytes_sent, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
